ram_nr1w: RTL and testbench
===========================

Name: ram_nr1w

Overview:
- Parametrised successor of the core's unified instruction/data memory.
- NRD independent synchronous read ports (fetch, LSU, debug, …) and one byte-masked write port.
- Registered 1-cycle read latency with valid flags, write-first forwarding and out-of-range error flags.
- Post-reset zero-initialisation sequencer, so the simulator and FPGA start from identical memory contents.

Parameters:
- ADDR_W, 64, byte-address width of every port.
- DATA_W, 64, word width; power of two, ≥16.
- DEPTH, 4096, number of DATA_W words; power of two.
- NRD, 2, number of read ports, 1..4.
- BASE, 64'h8000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ready  out  1  high once initialisation is done; requests are ignored while low.
- rd_en  in  NRD  per-port read request.
- rd_addr  in  NRD*ADDR_W  per-port byte address; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_valid  out  NRD  per-port data valid, one cycle after an accepted request.
- rd_data  out  NRD*DATA_W  per-port read word, packed like rd_addr.
- rd_err  out  NRD  per-port out-of-range flag, qualified by rd_valid.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write byte address.
- wr_data  in  DATA_W  write data.
- wr_mask  in  DATA_W/8  byte enables; bit b covers byte b.
- wr_err  out  1  pulses one cycle after a write to an out-of-range address is dropped.

Behaviour:
- Reset (async, any time, including mid-init):
  - State goes to INIT; clear counter goes to 0.
  - ready=0, rd_valid=0, rd_data=0, rd_err=0, wr_err=0.
- Address decode:
  - off = addr − BASE (ADDR_W-bit, wrapping).
  - idx = off >> log2(DATA_W/8); low offset bits are ignored (word-aligned access).
  - In range iff addr ≥ BASE and idx < DEPTH.
- State machine:
  - INIT: each cycle writes 0 to word[cnt] and increments cnt. When cnt = DEPTH−1 is written, go to RUN; ready=1 from the next cycle.
  - INIT lasts exactly DEPTH cycles after reset release.
  - In INIT, rd_en and wr_en are ignored: no rd_valid, no write, no wr_err.
  - RUN: terminal until reset.
- Read, in RUN with rd_en[i]=1 at edge N:
  - rd_valid[i]=1 during cycle N+1.
  - rd_data[i] = word[idx] as it exists after edge N's write (write-first, see forwarding).
  - rd_err[i]=0.
- Out-of-range read:
  - rd_valid[i]=1, rd_data[i]=0, rd_err[i]=1.
- No request:
  - rd_valid[i]=0 next cycle; rd_data[i] and rd_err[i] hold their last values.
- Write, in RUN with wr_en=1:
  - In range: at the edge, word[idx] byte b takes wr_data byte b where wr_mask[b]=1; other bytes are unchanged.
  - wr_mask=0 is a legal no-op.
  - Out of range: memory is unchanged; wr_err=1 for one cycle.
- Forwarding: when a read and a write target the same idx on the same edge, the read returns the merged word (masked new bytes plus old unmasked bytes).
- Port independence:
  - Read ports never stall or block each other.
  - Any number of ports may read the same word on the same cycle and all get identical data.
- Sustained throughput: one read per port per cycle plus one write per cycle, with no bubbles.

Test Plan:
- DEPTH=16: assert rst 3 cycles, release -> ready low for exactly 16 cycles then high; all reads of 0x8000_0000..0x8000_0078 return 0 with rd_err=0.
- Pre-fill word 2 with 64'hFFFF_FFFF_FFFF_FFFF. Write 0x8000_0010, data 64'h1122_3344_5566_7788, mask 8'h0F -> port 0 read the next cycle returns 64'hFFFF_FFFF_5566_7788.
- Word 2 = 64'hFFFF_FFFF_5566_7788. Same edge: write 0x8000_0010, data 64'hAA00_0000_0000_0000, mask 8'h80, plus reads on ports 0 and 1 -> both return 64'hAAFF_FFFF_5566_7788 next cycle, rd_valid=2'b11.
- Read 0x7FFF_FFF8 and 0x8000_0080 (DEPTH=16) -> rd_valid=1, rd_data=0, rd_err=1. Write 0x8000_0080 -> wr_err pulses one cycle, memory unchanged.
- Reassert rst at init cycle 7, release -> full 16-cycle INIT reruns. rd_en held high throughout -> rd_valid stays 0 until the cycle after ready rises.
- Back-to-back reads of words 0..15 on port 0 while port 1 reads 15..0 over 16 consecutive cycles -> 16 consecutive rd_valid pulses per port, correct data each cycle.

Source files
------------

// File: rtl/ram_nr1w.sv
// NRD-read / 1-write word memory: byte-masked writes, write-first forwarding, zeroing init sequencer.
// Read data is registered one cycle after acceptance; no backpressure once ready is high, requests ignored before.
module ram_nr1w #(
  parameter int unsigned       ADDR_W = 64,
  parameter int unsigned       DATA_W = 64,
  parameter int unsigned       DEPTH  = 4096,
  parameter int unsigned       NRD    = 2,
  parameter logic [ADDR_W-1:0] BASE   = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        rd_valid,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_err,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_mask,
  output logic                  wr_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic             ok;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Wrapping subtract; the >= test rejects addresses below BASE that wrap into range.
  function automatic dec_t f_decode(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] word;
    dec_t              d;
    off   = addr - BASE;
    word  = off >> OFF_W;
    d.idx = word[IDX_W-1:0];
    d.ok  = (addr >= BASE) && ((word >> IDX_W) == '0);
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [NB-1:0]     mask);
    logic [DATA_W-1:0] res;
    for (int b = 0; b < NB; b++) begin
      res[b*8 +: 8] = mask[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0]     r_mem [DEPTH];
  state_t                r_state;
  logic [IDX_W-1:0]      r_cnt;
  logic [NRD-1:0]        r_rd_valid;
  logic [NRD*DATA_W-1:0] r_rd_data;
  logic [NRD-1:0]        r_rd_err;
  logic                  r_wr_err;

  state_t                w_state_nxt;
  logic                  w_init;
  logic                  w_ready;
  dec_t                  w_wr_dec;
  logic [DATA_W-1:0]     w_wr_old;
  logic [DATA_W-1:0]     w_wr_word;
  logic                  w_wr_go;
  logic                  w_wr_bad;
  dec_t                  w_rd_dec  [NRD];
  logic [DATA_W-1:0]     w_rd_word [NRD];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_cnt == IDX_W'(DEPTH - 1)) begin
      w_state_nxt = S_RUN;
    end
  end

  always_comb begin
    w_init  = (r_state == S_INIT);
    w_ready = (r_state == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_init) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_wr_dec  = f_decode(wr_addr);
    w_wr_old  = r_mem[w_wr_dec.idx];
    w_wr_word = f_merge(w_wr_old, wr_data, wr_mask);
    w_wr_go   = w_ready && wr_en && w_wr_dec.ok;
    w_wr_bad  = w_ready && wr_en && !w_wr_dec.ok;
  end

  // Write-first: a read hitting the word being written sees the merged word.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      w_rd_dec[i]  = f_decode(rd_addr[i*ADDR_W +: ADDR_W]);
      w_rd_word[i] = '0;
      if (w_rd_dec[i].ok) begin
        if (w_wr_go && (w_wr_dec.idx == w_rd_dec[i].idx)) begin
          w_rd_word[i] = w_wr_word;
        end else begin
          w_rd_word[i] = r_mem[w_rd_dec[i].idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_init) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_go) begin
      r_mem[w_wr_dec.idx] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= '0;
      r_rd_data  <= '0;
      r_rd_err   <= '0;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_err <= w_wr_bad;
      for (int i = 0; i < NRD; i++) begin
        r_rd_valid[i] <= w_ready && rd_en[i];
        if (w_ready && rd_en[i]) begin
          r_rd_data[i*DATA_W +: DATA_W] <= w_rd_word[i];
          r_rd_err[i]                   <= !w_rd_dec[i].ok;
        end
      end
    end
  end

  assign ready    = w_ready;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_err   = r_rd_err;
  assign wr_err   = r_wr_err;

endmodule

// File: tb/tb_ram_nr1w.sv
// Directed bench for ram_nr1w (DEPTH=16, two read ports); stimulus pushes expectations, a monitor pops and compares.
`timescale 1ns/1ps
module tb_ram_nr1w;

  localparam int AW = 64, DW = 64, DEP = 16, NR = 2;
  localparam logic [63:0] B = 64'h8000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic [NR-1:0]    rd_en, rd_valid, rd_err;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic             wr_en, wr_err;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [DW/8-1:0]  wr_mask;

  ram_nr1w #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .NRD(NR), .BASE(B)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] d;
    logic        e;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   wq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [63:0] wa(input int k);
    return B + 64'(k) * 64'd8;
  endfunction

  function automatic logic [63:0] dk(input int k);
    return 64'h0101_0101_0101_0101 * 64'(k + 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_rd(input int p, input exp_t e);
    logic [63:0] d;
    logic        er;
    d  = rd_data[p*DW +: DW];
    er = rd_err[p];
    n_cmp++;
    if (e.cyc != cyc || d !== e.d || er !== e.e) begin
      n_bad++;
      $display("FAIL rd%0d: cycle %0d data %h err %b, want cycle %0d data %h err %b",
               p, cyc, d, er, e.cyc, e.d, e.e);
    end
  endtask

  task automatic push_rd(input int p, input logic [63:0] d, input logic e);
    exp_t x;
    x.cyc = cyc + 1;
    x.d   = d;
    x.e   = e;
    if (p == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // One cycle of stimulus; the accepting edge is the next posedge.
  task automatic issue(input logic [1:0] re,
                       input logic [63:0] a0, input logic [63:0] d0, input logic e0,
                       input logic [63:0] a1, input logic [63:0] d1, input logic e1,
                       input logic we, input logic [63:0] wad, input logic [63:0] wd,
                       input logic [7:0] wm, input logic werr);
    @(negedge clk); #1;
    rd_en   = re;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wad;
    wr_data = wd;
    wr_mask = wm;
    if (re[0]) push_rd(0, d0, e0);
    if (re[1]) push_rd(1, d1, e1);
    if (we && werr) wq.push_back(cyc + 1);
  endtask

  task automatic idle();
    issue(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0, 8'h00, 1'b0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin : mon
    exp_t e;
    int   c;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rd_valid[0]) begin
          if (q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rd0_unexpected: rd_valid at cycle %0d, want none", cyc);
          end else begin
            e = q0.pop_front();
            chk_rd(0, e);
          end
        end
        if (rd_valid[1]) begin
          if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rd1_unexpected: rd_valid at cycle %0d, want none", cyc);
          end else begin
            e = q1.pop_front();
            chk_rd(1, e);
          end
        end
        if (wr_err) begin
          if (wq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_err_unexpected: pulse at cycle %0d, want none", cyc);
          end else begin
            c = wq.pop_front();
            chk("wr_err_cycle", 64'(cyc), 64'(c));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", rd_data[63:0] | rd_data[127:64], 64'd0);
    chk("rst_err_flags", 64'({rd_err, wr_err}), 64'd0);
    #1 rst = 1'b0;
    wait_ready(n);
    chk("init_len", 64'(n), 64'd16);

    // Every word zeroed by the init sequencer.
    for (int i = 0; i < 16; i++) begin
      issue(2'b11, wa(i), 0, 1'b0, wa(15 - i), 0, 1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
    end

    issue(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, wa(2), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    issue(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, wa(2), 64'h1122_3344_5566_7788, 8'h0F, 1'b0);
    issue(2'b01, wa(2), 64'hFFFF_FFFF_5566_7788, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
    issue(2'b11, wa(2), 64'hAAFF_FFFF_5566_7788, 1'b0, wa(2), 64'hAAFF_FFFF_5566_7788, 1'b0,
          1'b1, wa(2), 64'hAA00_0000_0000_0000, 8'h80, 1'b0);
    idle();
    @(negedge clk);
    chk("hold_valid", 64'(rd_valid), 64'd0);
    chk("hold_data0", rd_data[63:0], 64'hAAFF_FFFF_5566_7788);
    chk("hold_data1", rd_data[127:64], 64'hAAFF_FFFF_5566_7788);

    // Zero mask is a no-op; unaligned address selects the containing word; other-word read sees old data.
    issue(2'b10, 0, 0, 1'b0, wa(2), 64'hAAFF_FFFF_5566_7788, 1'b0, 1'b1, wa(2), 64'h0, 8'h00, 1'b0);
    issue(2'b01, 64'h8000_0017, 64'hAAFF_FFFF_5566_7788, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
    issue(2'b11, wa(5), 64'h5555_5555_5555_5555, 1'b0, wa(4), 64'h0, 1'b0,
          1'b1, wa(5), 64'h5555_5555_5555_5555, 8'hFF, 1'b0);

    // Out-of-range reads and dropped writes.
    issue(2'b11, 64'h7FFF_FFF8, 64'h0, 1'b1, 64'h8000_0080, 64'h0, 1'b1, 1'b0, 0, 0, 8'h00, 1'b0);
    issue(2'b01, wa(0), 64'h0, 1'b0, 0, 0, 1'b0, 1'b1, 64'h8000_0080, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    issue(2'b11, wa(0), 64'h0, 1'b0, wa(15), 64'h0, 1'b0, 1'b1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    issue(2'b11, wa(0), 64'h0, 1'b0, wa(15), 64'h0, 1'b0, 1'b0, 0, 0, 8'h00, 1'b0);

    issue(2'b00, 0, 0, 0, 0, 0, 0, 1'b1, wa(12), 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
    issue(2'b01, wa(12), 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
    idle();

    // Reset again, interrupt init at cycle 7, requests held active throughout.
    @(negedge clk); #1;
    rst = 1'b1;
    rd_en = 2'b11; rd_addr = {wa(12), wa(12)};
    wr_en = 1'b1; wr_addr = 64'h8000_0080; wr_data = '1; wr_mask = '1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wait_ready(n);
    chk("reinit_len", 64'(n), 64'd16);
    #1;
    wr_en = 1'b0;
    push_rd(0, 64'h0, 1'b0);
    push_rd(1, 64'h0, 1'b0);
    idle();

    // Sustained write + forwarded read + previous-word read every cycle.
    for (int k = 0; k < 16; k++) begin
      issue(2'b11, wa(k), dk(k), 1'b0, wa(k == 0 ? 15 : k - 1), (k == 0 ? 64'h0 : dk(k - 1)), 1'b0,
            1'b1, wa(k), dk(k), 8'hFF, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      issue(2'b11, wa(i), dk(i), 1'b0, wa(15 - i), dk(15 - i), 1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
    end
    idle();
    idle();
    @(negedge clk);

    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("wq_drained", 64'(wq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
